bzled_seq: RTL and testbench

Setpoint sequencer feeding `perip_BZLED`. It accepts register writes over a valid/ready command port and holds each write in a single-entry buffer until the next LED PWM period boundary, so the LEDs and buzzer never see a mid-period glitch. It drives the five 32-bit setpoints of `perip_BZLED`, optionally ramps LED duty as a "breathing" effect, and times buzzer beeps in LED periods.

---
 rtl/bzled_seq.sv | 185 ++++++++++++++++++
 tb/tb_bzled_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bzled_seq.sv
// Setpoint sequencer for perip_BZLED: buffers one register write until the next LED period boundary.
// Optional breathing (LED duty ramp) compiled in with `define BZLED_BREATH_EN.
module bzled_seq #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49998,
    parameter logic [31:0] BEEP_MUTE      = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_Valid,
    output logic        CMD_Ready,
    input  logic [2:0]  CMD_Addr,
    input  logic [31:0] CMD_Data,
    output logic [31:0] LED_FREQ_Set,
    output logic [31:0] BZ_FREQ_Set,
    output logic [31:0] LEDR_Puty_Set,
    output logic [31:0] LEDG_Puty_Set,
    output logic [31:0] LEDB_Puty_Set,
    output logic        Period_Tick,
    output logic        Beep_Busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state;
    logic [2:0]  pend_addr;
    logic [31:0] pend_data;
    logic [31:0] per_cnt;
    logic [31:0] tone, tgt_r, tgt_g, tgt_b, beep_cnt;
    logic        buzz_on;
    logic        commit;

    logic [31:0] freq_n, tone_n, r_n, g_n, b_n, beep_n;
    logic        buzz_on_n;
    logic [31:0] duty_r, duty_g, duty_b;

`ifdef BZLED_BREATH_EN
    logic [31:0] step, step_n, lvl, lvl_n;
    logic        dir, dir_n, breath_on, breath_on_n;

    function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // Returns {dir, lvl}; dir = 1 means ramping down. Sum is kept 33-bit so it cannot wrap.
    function automatic logic [32:0] breath_step(input logic [31:0] l, input logic d,
                                                input logic [31:0] s, input logic [31:0] f);
        logic [32:0] sum;
        sum = {1'b0, l} + {1'b0, s};
        if (!d) begin
            if (sum >= {1'b0, f}) return {1'b1, f};
            return {1'b0, sum[31:0]};
        end
        if (l <= s) return {1'b0, 32'd0};
        return {1'b1, l - s};
    endfunction
`endif

    assign Period_Tick = (per_cnt > LED_FREQ_Set);
    assign Beep_Busy   = (beep_cnt != 32'd0);
    assign commit      = (state == HOLD) && Period_Tick;

    // Register values as they will stand after this boundary, pending write folded in.
    always_comb begin
        freq_n    = LED_FREQ_Set;
        tone_n    = tone;
        r_n       = tgt_r;
        g_n       = tgt_g;
        b_n       = tgt_b;
        buzz_on_n = buzz_on;
        beep_n    = Beep_Busy ? beep_cnt - 32'd1 : 32'd0;
`ifdef BZLED_BREATH_EN
        step_n      = step;
        breath_on_n = breath_on;
`endif
        if (commit) begin
            case (pend_addr)
                3'd0: freq_n = pend_data;
                3'd1: tone_n = pend_data;
                3'd2: r_n    = pend_data;
                3'd3: g_n    = pend_data;
                3'd4: b_n    = pend_data;
`ifdef BZLED_BREATH_EN
                3'd5: step_n = pend_data;
                3'd6: begin
                    breath_on_n = pend_data[0];
                    buzz_on_n   = pend_data[1];
                end
`else
                3'd6: buzz_on_n = pend_data[1];
`endif
                3'd7: beep_n = pend_data;
                default: ;
            endcase
        end
    end

`ifdef BZLED_BREATH_EN
    // Ramp uses pre-commit mode/step/period; a commit that clears breathing wins.
    always_comb begin
        lvl_n = lvl;
        dir_n = dir;
        if (!breath_on_n) begin
            lvl_n = 32'd0;
            dir_n = 1'b0;
        end else if (breath_on) begin
            {dir_n, lvl_n} = breath_step(lvl, dir, step, LED_FREQ_Set);
        end
    end

    assign duty_r = breath_on_n ? umin(lvl_n, r_n) : r_n;
    assign duty_g = breath_on_n ? umin(lvl_n, g_n) : g_n;
    assign duty_b = breath_on_n ? umin(lvl_n, b_n) : b_n;
`else
    assign duty_r = r_n;
    assign duty_g = g_n;
    assign duty_b = b_n;
`endif

    always_ff @(posedge CLK) begin
        if (state == IDLE && CMD_Valid) begin
            pend_addr <= CMD_Addr;
            pend_data <= CMD_Data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            CMD_Ready     <= 1'b1;
            per_cnt       <= 32'd0;
            LED_FREQ_Set  <= PERIOD_DEFAULT;
            BZ_FREQ_Set   <= BEEP_MUTE;
            LEDR_Puty_Set <= 32'd0;
            LEDG_Puty_Set <= 32'd0;
            LEDB_Puty_Set <= 32'd0;
            tone          <= 32'd0;
            tgt_r         <= 32'd0;
            tgt_g         <= 32'd0;
            tgt_b         <= 32'd0;
            beep_cnt      <= 32'd0;
            buzz_on       <= 1'b0;
`ifdef BZLED_BREATH_EN
            step          <= 32'd0;
            lvl           <= 32'd0;
            dir           <= 1'b0;
            breath_on     <= 1'b0;
`endif
        end else begin
            per_cnt <= Period_Tick ? 32'd0 : per_cnt + 32'd1;

            case (state)
                IDLE: if (CMD_Valid && CMD_Ready) begin
                    state     <= HOLD;
                    CMD_Ready <= 1'b0;
                end
                HOLD: if (Period_Tick) begin
                    state     <= IDLE;
                    CMD_Ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (Period_Tick) begin
                LED_FREQ_Set  <= freq_n;
                tone          <= tone_n;
                tgt_r         <= r_n;
                tgt_g         <= g_n;
                tgt_b         <= b_n;
                buzz_on       <= buzz_on_n;
                beep_cnt      <= beep_n;
                BZ_FREQ_Set   <= (buzz_on_n || beep_n != 32'd0) ? tone_n : BEEP_MUTE;
                LEDR_Puty_Set <= duty_r;
                LEDG_Puty_Set <= duty_g;
                LEDB_Puty_Set <= duty_b;
`ifdef BZLED_BREATH_EN
                step          <= step_n;
                breath_on     <= breath_on_n;
                lvl           <= lvl_n;
                dir           <= dir_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bzled_seq.sv
// Directed bench for bzled_seq: write table plus hand sequences for boundary, beep, breath and reset cases.
module tb_bzled_seq;

    localparam logic [31:0] PDEF = 32'd49998;
    localparam logic [31:0] MUTE = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_Valid = 1'b0;
    logic        CMD_Ready;
    logic [2:0]  CMD_Addr = 3'd0;
    logic [31:0] CMD_Data = 32'd0;
    logic [31:0] LED_FREQ_Set, BZ_FREQ_Set, LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set;
    logic        Period_Tick, Beep_Busy;

    int checks = 0;
    int errors = 0;

    bzled_seq dut (
        .CLK(CLK), .RST(RST),
        .CMD_Valid(CMD_Valid), .CMD_Ready(CMD_Ready), .CMD_Addr(CMD_Addr), .CMD_Data(CMD_Data),
        .LED_FREQ_Set(LED_FREQ_Set), .BZ_FREQ_Set(BZ_FREQ_Set),
        .LEDR_Puty_Set(LEDR_Puty_Set), .LEDG_Puty_Set(LEDG_Puty_Set), .LEDB_Puty_Set(LEDB_Puty_Set),
        .Period_Tick(Period_Tick), .Beep_Busy(Beep_Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] freq, bz, r, g, b;
        logic        busy;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        while (!Period_Tick && n < max) begin
            @(negedge CLK);
            n++;
        end
        if (!Period_Tick) check("tick_timeout", 32'd0, 32'd1);
    endtask

    // Issue one write and return at the negedge after it has been committed.
    task automatic send_commit(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        while (!CMD_Ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        CMD_Valid = 1'b1;
        CMD_Addr  = a;
        CMD_Data  = d;
        @(negedge CLK);
        CMD_Valid = 1'b0;
        check("ready_low_in_hold", CMD_Ready, 32'd0);
        n = 0;
        while (!CMD_Ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("commit_timeout", CMD_Ready, 32'd1);
    endtask

    initial begin
        int n;
        int early_tick;
        int ready_drop;
        tbl[0] = '{3'd2, 32'd5,      32'd8, MUTE,      32'd5, 32'd0, 32'd0,      1'b0};
        tbl[1] = '{3'd4, 32'h1234,   32'd8, MUTE,      32'd5, 32'd0, 32'h1234,   1'b0};
        tbl[2] = '{3'd1, 32'd100,    32'd8, MUTE,      32'd5, 32'd0, 32'h1234,   1'b0};
        tbl[3] = '{3'd6, 32'd2,      32'd8, 32'd100,   32'd5, 32'd0, 32'h1234,   1'b0};
        tbl[4] = '{3'd6, 32'd0,      32'd8, MUTE,      32'd5, 32'd0, 32'h1234,   1'b0};
        tbl[5] = '{3'd5, 32'd3,      32'd8, MUTE,      32'd5, 32'd0, 32'h1234,   1'b0};
        tbl[6] = '{3'd3, 32'd7,      32'd8, MUTE,      32'd5, 32'd7, 32'h1234,   1'b0};

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_freq", LED_FREQ_Set, PDEF);
        check("rst_bz", BZ_FREQ_Set, MUTE);
        check("rst_r", LEDR_Puty_Set, 32'd0);
        check("rst_g", LEDG_Puty_Set, 32'd0);
        check("rst_b", LEDB_Puty_Set, 32'd0);
        check("rst_ready", CMD_Ready, 32'd1);
        check("rst_busy", Beep_Busy, 32'd0);
        RST = 1'b0;

        // Idle through the default period, then land the FREQ write just before the first tick
        early_tick = 0;
        ready_drop = 0;
        for (int i = 0; i < 49998; i++) begin
            if (Period_Tick) early_tick++;
            if (!CMD_Ready) ready_drop++;
            @(negedge CLK);
        end
        check("idle_no_early_tick", early_tick, 32'd0);
        check("idle_ready_high", ready_drop, 32'd0);
        check("idle_freq", LED_FREQ_Set, PDEF);
        check("idle_bz", BZ_FREQ_Set, MUTE);
        CMD_Valid = 1'b1;
        CMD_Addr  = 3'd0;
        CMD_Data  = 32'd8;
        @(negedge CLK);
        CMD_Valid = 1'b0;
        check("first_tick_at_50000", Period_Tick, 32'd1);
        check("freq_hold_ready", CMD_Ready, 32'd0);
        check("freq_not_yet", LED_FREQ_Set, PDEF);
        @(negedge CLK);
        check("freq_committed", LED_FREQ_Set, 32'd8);
        check("freq_ready_back", CMD_Ready, 32'd1);

        // Period is now 10 cycles
        wait_tick(200, n);
        check("period8_first", n, 32'd9);
        @(negedge CLK);
        wait_tick(200, n);
        check("period8_second", n, 32'd9);
        @(negedge CLK);

        // Table of single writes
        for (int i = 0; i < 7; i++) begin
            send_commit(tbl[i].addr, tbl[i].data);
            check($sformatf("v%0d_freq", i), LED_FREQ_Set, tbl[i].freq);
            check($sformatf("v%0d_bz", i), BZ_FREQ_Set, tbl[i].bz);
            check($sformatf("v%0d_r", i), LEDR_Puty_Set, tbl[i].r);
            check($sformatf("v%0d_g", i), LEDG_Puty_Set, tbl[i].g);
            check($sformatf("v%0d_b", i), LEDB_Puty_Set, tbl[i].b);
            check($sformatf("v%0d_busy", i), Beep_Busy, tbl[i].busy);
        end

        // Timed beep: 3 periods of tone, mute and Busy drop together
        send_commit(3'd7, 32'd3);
        check("beep_bz_on", BZ_FREQ_Set, 32'd100);
        check("beep_busy_on", Beep_Busy, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(200, n);
            @(negedge CLK);
            check($sformatf("beep_bz_%0d", k), BZ_FREQ_Set, (k < 3) ? 32'd100 : MUTE);
            check($sformatf("beep_busy_%0d", k), Beep_Busy, (k < 3) ? 32'd1 : 32'd0);
        end
        send_commit(3'd7, 32'd5);
        check("beep2_busy", Beep_Busy, 32'd1);
        send_commit(3'd7, 32'd0);
        check("beep_cancel_busy", Beep_Busy, 32'd0);
        check("beep_cancel_bz", BZ_FREQ_Set, MUTE);

        // Write accepted in the tick cycle waits one full period; held Valid is not re-accepted
        wait_tick(200, n);
        CMD_Valid = 1'b1;
        CMD_Addr  = 3'd3;
        CMD_Data  = 32'd9;
        @(negedge CLK);
        check("tick_accept_ready", CMD_Ready, 32'd0);
        check("tick_accept_not_commit", LEDG_Puty_Set, 32'd7);
        CMD_Data = 32'd11;
        wait_tick(200, n);
        check("tick_accept_wait", n, 32'd9);
        check("tick_accept_g_before", LEDG_Puty_Set, 32'd7);
        CMD_Valid = 1'b0;
        @(negedge CLK);
        check("tick_accept_g", LEDG_Puty_Set, 32'd9);
        check("tick_accept_ready_back", CMD_Ready, 32'd1);
        wait_tick(200, n);
        @(negedge CLK);
        check("no_second_accept", LEDG_Puty_Set, 32'd9);

`ifdef BZLED_BREATH_EN
        begin
            logic [31:0] lv [7];
            lv = '{32'd3, 32'd6, 32'd8, 32'd5, 32'd2, 32'd0, 32'd3};
            send_commit(3'd2, 32'd8);
            send_commit(3'd3, 32'd4);
            send_commit(3'd4, 32'd8);
            send_commit(3'd5, 32'd3);
            send_commit(3'd6, 32'd1);
            check("breath_start_r", LEDR_Puty_Set, 32'd0);
            for (int k = 0; k < 7; k++) begin
                wait_tick(200, n);
                @(negedge CLK);
                check($sformatf("breath_r_%0d", k), LEDR_Puty_Set, lv[k]);
                check($sformatf("breath_g_%0d", k), LEDG_Puty_Set, (lv[k] < 32'd4) ? lv[k] : 32'd4);
            end
            send_commit(3'd6, 32'd0);
            check("breath_off_r", LEDR_Puty_Set, 32'd8);
            check("breath_off_g", LEDG_Puty_Set, 32'd4);
        end
`endif

        // Async reset during HOLD discards the pending write
        send_commit(3'd6, 32'd2);
        send_commit(3'd7, 32'd50);
        check("pre_rst_bz", BZ_FREQ_Set, 32'd100);
        CMD_Valid = 1'b1;
        CMD_Addr  = 3'd0;
        CMD_Data  = 32'd3;
        @(negedge CLK);
        CMD_Valid = 1'b0;
        check("pre_rst_hold", CMD_Ready, 32'd0);
        #2 RST = 1'b1;
        #1;
        check("arst_freq", LED_FREQ_Set, PDEF);
        check("arst_bz", BZ_FREQ_Set, MUTE);
        check("arst_r", LEDR_Puty_Set, 32'd0);
        check("arst_g", LEDG_Puty_Set, 32'd0);
        check("arst_b", LEDB_Puty_Set, 32'd0);
        check("arst_ready", CMD_Ready, 32'd1);
        check("arst_busy", Beep_Busy, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("post_rst_write_lost", LED_FREQ_Set, PDEF);
        check("post_rst_ready", CMD_Ready, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
